// File: rtl/nexthop_dispatch.sv
// nexthop_dispatch: per-input NoC packet dispatcher.
// Captures one packet, drives the next-hop lookup, waits a fixed latency,
// checks that the chosen route is one-hot and hands the packet to exactly
// one output port over valid/ready (or drops it on a bad route).
//
// Ports:
//   clk, rst          clock, async active-low reset
//   in_valid/in_ready input packet handshake
//   in_hit            1 = use lk_nhop, 0 = use lk_mem_nhop
//   in_dest, in_data  packet destination and payload
//   lk_addr           address presented to the next-hop lookup
//   lk_nhop           lookup route select (directory hit)
//   lk_mem_nhop       route select toward the memory node (miss)
//   out_valid         per-port valid, at most one bit set
//   out_ready         per-port ready
//   out_dest/out_data captured packet fields
//   busy              state is not IDLE
//   sent_cnt          delivered packets, saturating
//   route_err_cnt     dropped packets (non-one-hot route), saturating
module nexthop_dispatch #(
    parameter int DESTWIDTH    = 8,
    parameter int NEXTHOPWIDTH = 4,
    parameter int DATAWIDTH    = 32,
    parameter int CNTWIDTH     = 16,
    parameter int LOOKUP_LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_hit,
    input  logic [DESTWIDTH-1:0]    in_dest,
    input  logic [DATAWIDTH-1:0]    in_data,
    output logic [DESTWIDTH-1:0]    lk_addr,
    input  logic [NEXTHOPWIDTH-1:0] lk_nhop,
    input  logic [NEXTHOPWIDTH-1:0] lk_mem_nhop,
    output logic [NEXTHOPWIDTH-1:0] out_valid,
    input  logic [NEXTHOPWIDTH-1:0] out_ready,
    output logic [DESTWIDTH-1:0]    out_dest,
    output logic [DATAWIDTH-1:0]    out_data,
    output logic                    busy,
    output logic [CNTWIDTH-1:0]     sent_cnt,
    output logic [CNTWIDTH-1:0]     route_err_cnt
);

    localparam int LATW = 2;
    localparam logic [LATW-1:0] LAT_INIT = LATW'(LOOKUP_LAT - 1);
    localparam logic [LATW-1:0] LAT_ONE  = LATW'(1);
    localparam logic [NEXTHOPWIDTH-1:0] NH_ONE = NEXTHOPWIDTH'(1);
    localparam logic [CNTWIDTH-1:0] CNT_ONE = CNTWIDTH'(1);
    localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        SEND,
        DROP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [LATW-1:0]         lat_q;
    logic                    hit_q;
    logic [NEXTHOPWIDTH-1:0] route_q;
    logic [NEXTHOPWIDTH-1:0] route_d;
    logic                    route_ok;
    logic                    lat_done;
    logic                    capture;
    logic                    handshake;

    // Route candidate as seen on the sampling edge.
    assign route_d = hit_q ? lk_nhop : lk_mem_nhop;

    // One-hot: nonzero and clearing the lowest set bit leaves nothing.
    assign route_ok = (route_d != '0) &&
                      ((route_d & (route_d - NH_ONE)) == '0);

    assign lat_done = (lat_q == '0);
    assign capture  = (state_q == IDLE) && in_valid;

    // Only the selected port's ready matters; route_q is one-hot in SEND.
    assign handshake = (state_q == SEND) && ((route_q & out_ready) != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lat_done) begin
                    state_d = route_ok ? SEND : DROP;
                end
            end
            SEND: begin
                out_valid = route_q;
                if (handshake) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Packet capture, latency counter and route register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lk_addr  <= '0;
            out_dest <= '0;
            out_data <= '0;
            hit_q    <= 1'b0;
            lat_q    <= '0;
            route_q  <= '0;
        end else begin
            if (capture) begin
                lk_addr  <= in_dest;
                out_dest <= in_dest;
                out_data <= in_data;
                hit_q    <= in_hit;
                lat_q    <= LAT_INIT;
            end
            if (state_q == LOOKUP) begin
                if (lat_done) begin
                    route_q <= route_d;
                end else begin
                    lat_q <= lat_q - LAT_ONE;
                end
            end
        end
    end

    // Saturating status counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sent_cnt      <= '0;
            route_err_cnt <= '0;
        end else begin
            if (handshake && (sent_cnt != CNT_MAX)) begin
                sent_cnt <= sent_cnt + CNT_ONE;
            end
            if ((state_q == DROP) && (route_err_cnt != CNT_MAX)) begin
                route_err_cnt <= route_err_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_nexthop_dispatch.sv
// tb_nexthop_dispatch: directed scoreboard bench for nexthop_dispatch.
// Stimulus pushes expected deliveries; a negedge monitor pops on handshake.
module tb_nexthop_dispatch;

    localparam int DW  = 8;
    localparam int NH  = 4;
    localparam int DAT = 32;
    localparam int CW  = 4;
    localparam int LAT = 2;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           in_hit;
    logic [DW-1:0]  in_dest;
    logic [DAT-1:0] in_data;
    logic [DW-1:0]  lk_addr;
    logic [NH-1:0]  lk_nhop;
    logic [NH-1:0]  lk_mem_nhop;
    logic [NH-1:0]  out_valid;
    logic [NH-1:0]  out_ready;
    logic [DW-1:0]  out_dest;
    logic [DAT-1:0] out_data;
    logic           busy;
    logic [CW-1:0]  sent_cnt;
    logic [CW-1:0]  route_err_cnt;

    nexthop_dispatch #(
        .DESTWIDTH(DW),
        .NEXTHOPWIDTH(NH),
        .DATAWIDTH(DAT),
        .CNTWIDTH(CW),
        .LOOKUP_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_hit(in_hit),
        .in_dest(in_dest),
        .in_data(in_data),
        .lk_addr(lk_addr),
        .lk_nhop(lk_nhop),
        .lk_mem_nhop(lk_mem_nhop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_dest(out_dest),
        .out_data(out_data),
        .busy(busy),
        .sent_cnt(sent_cnt),
        .route_err_cnt(route_err_cnt)
    );

    typedef struct packed {
        logic [NH-1:0]  port;
        logic [DW-1:0]  dest;
        logic [DAT-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a packet and returns just after the capture edge E0.
    task automatic issue(input logic hit, input logic [DW-1:0] dest,
                         input logic [DAT-1:0] data,
                         input logic [NH-1:0] nh,
                         input logic [NH-1:0] mem);
        in_valid    = 1'b1;
        in_hit      = hit;
        in_dest     = dest;
        in_data     = data;
        lk_nhop     = nh;
        lk_mem_nhop = mem;
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: every delivery must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && (out_valid != '0)) begin
            chk("valid_onehot", 64'($onehot(out_valid)), 64'(1));
            if ((out_valid & out_ready) != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery: got port %0h expected none",
                             out_valid);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("deliv_port", 64'(out_valid), 64'(e.port));
                    chk("deliv_dest", 64'(out_dest), 64'(e.dest));
                    chk("deliv_data", 64'(out_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [NH-1:0] bad [2];
    int            exp_sent;

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_hit      = 1'b0;
        in_dest     = '0;
        in_data     = '0;
        lk_nhop     = '0;
        lk_mem_nhop = '0;
        out_ready   = '0;
        bad[0]      = 4'b0000;
        bad[1]      = 4'b0110;

        // Reset state
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sent", 64'(sent_cnt), 64'(0));
        chk("rst_err", 64'(route_err_cnt), 64'(0));
        chk("rst_lk_addr", 64'(lk_addr), 64'(0));
        tick();
        tick();
        rst = 1'b1;
        chk("rel_in_ready", 64'(in_ready), 64'(1));

        // 1: directory hit
        out_ready = '1;
        exp_q.push_back('{4'b0100, 8'h15, 32'hDEADBEEF});
        issue(1'b1, 8'h15, 32'hDEADBEEF, 4'b0100, 4'b0000);
        chk("t1_lk_addr", 64'(lk_addr), 64'(8'h15));
        chk("t1_busy", 64'(busy), 64'(1));
        chk("t1_in_ready", 64'(in_ready), 64'(0));
        tick();
        chk("t1_e1_valid", 64'(out_valid), 64'(0));
        tick();
        chk("t1_e2_valid", 64'(out_valid), 64'(4'b0100));
        chk("t1_dest", 64'(out_dest), 64'(8'h15));
        chk("t1_data", 64'(out_data), 64'(32'hDEADBEEF));
        tick();
        chk("t1_sent", 64'(sent_cnt), 64'(1));
        chk("t1_idle_ready", 64'(in_ready), 64'(1));
        chk("t1_idle_busy", 64'(busy), 64'(0));
        chk("t1_lk_hold", 64'(lk_addr), 64'(8'h15));

        // 2: miss path
        exp_q.push_back('{4'b0001, 8'h2A, 32'h12345678});
        issue(1'b0, 8'h2A, 32'h12345678, 4'b0010, 4'b0001);
        tick();
        tick();
        chk("t2_valid", 64'(out_valid), 64'(4'b0001));
        tick();
        chk("t2_sent", 64'(sent_cnt), 64'(2));

        // 3: bad routes are dropped
        for (int k = 0; k < 2; k++) begin
            issue(1'b1, 8'(8'h60 + k), 32'h0, bad[k], 4'b0001);
            tick();
            tick();
            chk("t3_valid", 64'(out_valid), 64'(0));
            chk("t3_drop_ready", 64'(in_ready), 64'(0));
            tick();
            chk("t3_err", 64'(route_err_cnt), 64'(k + 1));
            chk("t3_ready", 64'(in_ready), 64'(1));
            chk("t3_busy", 64'(busy), 64'(0));
        end
        chk("t3_sent", 64'(sent_cnt), 64'(2));

        // 4: backpressure on the selected port only
        out_ready = 4'b0001;
        exp_q.push_back('{4'b0100, 8'h77, 32'hCAFEF00D});
        issue(1'b1, 8'h77, 32'hCAFEF00D, 4'b0100, 4'b0010);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t4_valid", 64'(out_valid), 64'(4'b0100));
            chk("t4_data", 64'(out_data), 64'(32'hCAFEF00D));
            chk("t4_in_ready", 64'(in_ready), 64'(0));
            tick();
        end
        chk("t4_sent_hold", 64'(sent_cnt), 64'(2));
        out_ready = 4'b0101;
        tick();
        chk("t4_sent", 64'(sent_cnt), 64'(3));
        chk("t4_busy", 64'(busy), 64'(0));

        // 5: saturation of sent_cnt
        out_ready = '1;
        exp_sent  = 3;
        for (int i = 0; i < 20; i++) begin
            logic [NH-1:0] port;
            logic          hit;
            port = 4'(1 << (i % 4));
            hit  = i[0];
            exp_q.push_back('{port, 8'(8'h40 + i), 32'hA0000000 + i});
            issue(hit, 8'(8'h40 + i), 32'hA0000000 + i,
                  hit ? port : 4'b1111, hit ? 4'b1111 : port);
            tick();
            tick();
            tick();
            exp_sent = (exp_sent == 15) ? 15 : exp_sent + 1;
            chk("t5_sent", 64'(sent_cnt), 64'(exp_sent));
        end

        // 6: reset in the middle of SEND
        out_ready = '0;
        issue(1'b1, 8'h99, 32'h55AA55AA, 4'b0010, 4'b0000);
        tick();
        tick();
        chk("t6_valid", 64'(out_valid), 64'(4'b0010));
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'(0));
        chk("t6_rst_sent", 64'(sent_cnt), 64'(0));
        chk("t6_rst_err", 64'(route_err_cnt), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_data", 64'(out_data), 64'(0));
        chk("t6_rst_lk", 64'(lk_addr), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("t6_rel_ready", 64'(in_ready), 64'(1));
        chk("t6_rel_busy", 64'(busy), 64'(0));
        out_ready = '1;
        exp_q.push_back('{4'b1000, 8'h3C, 32'h0BADCAFE});
        issue(1'b1, 8'h3C, 32'h0BADCAFE, 4'b1000, 4'b0000);
        tick();
        tick();
        chk("t6_valid2", 64'(out_valid), 64'(4'b1000));
        tick();
        chk("t6_sent", 64'(sent_cnt), 64'(1));
        chk("t6_busy", 64'(busy), 64'(0));

        tick();
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nexthop_dispatch.md
# nexthop_dispatch

Per-input packet dispatcher that drives the hop-selection lookup and acts on its result. It takes one packet, presents its destination address to the next-hop lookup, and waits a fixed latency. It then selects the directory route (hit) or the memory route (miss), checks that the route is one-hot, and hands the packet to exactly one router output port over a valid/ready handshake. It sits between an input buffer of a NoC router and the crossbar. One instance serves each router input.

## Interface

Parameters:
- DESTWIDTH, default 8: destination address width; matches `DESTWIDTH`.
- NEXTHOPWIDTH, default 4: number of router output ports; one select bit each.
- DATAWIDTH, default 32: payload width.
- CNTWIDTH, default 16: width of the status counters.
- LOOKUP_LAT, default 2, legal range 1..4: rising edges from the packet-capture edge to the edge that samples `lk_nhop`/`lk_mem_nhop`.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- in_valid  in  1  input packet valid.
- in_ready  out  1  dispatcher can accept a packet.
- in_hit  in  1  1 = directory hit (use `lk_nhop`); 0 = miss (use `lk_mem_nhop`).
- in_dest  in  DESTWIDTH  packet destination address.
- in_data  in  DATAWIDTH  packet payload.
- lk_addr  out  DESTWIDTH  address driven to the next-hop lookup.
- lk_nhop  in  NEXTHOPWIDTH  route select for `lk_addr`.
- lk_mem_nhop  in  NEXTHOPWIDTH  route select toward the memory node.
- out_valid  out  NEXTHOPWIDTH  per-port valid; at most one bit is set.
- out_ready  in  NEXTHOPWIDTH  per-port ready.
- out_dest  out  DESTWIDTH  captured destination.
- out_data  out  DATAWIDTH  captured payload.
- busy  out  1  1 whenever the state is not IDLE.
- sent_cnt  out  CNTWIDTH  packets delivered; saturating.
- route_err_cnt  out  CNTWIDTH  packets dropped for a non-one-hot route; saturating.

## Operation

States: IDLE, LOOKUP, SEND, DROP. Encoding is free.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: register `in_dest`→`out_dest` and `lk_addr`, `in_data`→`out_data`, and `in_hit`.
  - Load the latency counter with LOOKUP_LAT−1 and go to LOOKUP.
- **LOOKUP**
  - Counter decrements every cycle.
  - On the edge where the counter is 0, sample route = hit ? `lk_nhop` : `lk_mem_nhop` into a route register.
  - Route exactly one-hot → SEND. Route zero or multi-hot → DROP.
- **SEND**
  - `out_valid` = route register.
  - `out_dest`/`out_data` are held stable.
  - Wait for `out_ready[k]` on the selected port k only; `out_ready` on other ports is ignored.
  - On the handshake: `sent_cnt`+1 (saturates at all-ones), go to IDLE.
- **DROP**
  - Lasts one cycle with `out_valid`=0.
  - `route_err_cnt`+1 (saturating), then go to IDLE.
- **Input acceptance**
  - `in_ready`=0 in LOOKUP, SEND and DROP.
  - `in_valid` in those states is ignored, not queued.
- **Lookup address**
  - `lk_addr` holds the last captured address until the next capture.
- **Reset**
  - Asynchronous, mid-operation included.
  - State→IDLE; `out_valid`, `out_dest`, `out_data`, `lk_addr`, route register, both counters → 0.
  - Any packet in flight is lost.
  - `in_ready`=1 from the first cycle after `rst` is released.

## Timing

- Capture edge is E0; the route is sampled at E(LOOKUP_LAT).
- `out_valid` is asserted in the cycle after E(LOOKUP_LAT).
- Minimum packet period is LOOKUP_LAT+2 cycles (the SEND handshake is in the first SEND cycle).
- Reset values: `in_ready`=1, `busy`=0, all other outputs 0.
- Counters update on the handshake or DROP edge; the new value is visible the next cycle.
- The lookup must present a stable route by the sampling edge. With a registered lookup, LOOKUP_LAT=2.

## Test plan

1. **Directory hit.** LOOKUP_LAT=2, `in_hit`=1, `in_dest`=0x15, `in_data`=0xDEADBEEF, `lk_nhop`=4'b0100, `out_ready`=all 1.
   - `lk_addr`=0x15 after E0.
   - `out_valid`=4'b0100 in the cycle after E2, with `out_dest`=0x15 and `out_data`=0xDEADBEEF.
   - `sent_cnt`=1, then back to IDLE.
2. **Miss path.** `in_hit`=0, `lk_nhop`=4'b0010, `lk_mem_nhop`=4'b0001.
   - `out_valid`=4'b0001.
   - 4'b0010 is never asserted.
3. **Bad route.** Two packets with route 4'b0000, then 4'b0110.
   - `out_valid` stays 0.
   - `route_err_cnt`=1, then 2.
   - `in_ready`=1 two cycles after each sampling edge.
4. **Backpressure.** Selected port 2 has `out_ready[2]`=0 for 10 cycles while `out_ready[0]`=1.
   - `out_valid`=4'b0100 is held with data stable and `in_ready`=0.
   - Delivery happens in the first cycle `out_ready[2]`=1; `sent_cnt` increments once.
5. **Saturation.** CNTWIDTH=4, 20 good packets.
   - `sent_cnt`=15 and holds at 15.
6. **Reset mid-SEND.** Drop `rst` to 0 while in SEND.
   - `out_valid`=0 and all counters 0 immediately, without waiting for a clock edge.
   - After release: `in_ready`=1, `busy`=0, and the next packet is dispatched normally.
